// File: rtl/string_pkg.sv
// Shared constants and state encoding for the string assembler and for any
// consumer that decodes the packed string (e.g. length_finder).
package string_pkg;

    localparam int unsigned STR_BYTES = 8;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned STR_W     = STR_BYTES * 8;

    localparam logic [7:0] NUL = 8'h00;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/length_finder.sv
// length_finder: returns the index of the first NUL lane of a packed string,
// or STR_BYTES when no lane is NUL.
// Ports:
//   str_in  packed string, lane k in bits [8k+7:8k]
//   len_c   combinational first-NUL index, 0..STR_BYTES
module length_finder
    import string_pkg::*;
(
    input  logic [STR_W-1:0] str_in,
    output logic [LEN_W-1:0] len_c
);

    // Scan from the top lane down so the lowest NUL lane wins.
    always_comb begin
        len_c = LEN_W'(STR_BYTES);
        for (int unsigned i = STR_BYTES; i > 0; i--) begin
            if (str_in[(i-1)*8 +: 8] == NUL) begin
                len_c = LEN_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/string_assembler.sv
// string_assembler: collects NUL-terminated byte strings (max STR_BYTES
// characters) into a packed word and presents it with a valid/ready handshake.
// Optional feature: define STRING_ASSEMBLER_ABORT_EN to add the abort input.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   abort         (STRING_ASSEMBLER_ABORT_EN only) drop the partial string
//   in_byte       incoming character, NUL terminates
//   in_valid      in_byte valid
//   in_ready      block accepts a byte (high while collecting)
//   string_data   packed string, character 0 in bits [7:0]
//   length        number of non-NUL characters, 0..STR_BYTES
//   out_valid     string_data/length hold a completed string
//   out_ready     consumer takes the completed string
module string_assembler
    import string_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
`ifdef STRING_ASSEMBLER_ABORT_EN
    input  logic             abort,
`endif
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [STR_W-1:0] string_data,
    output logic [LEN_W-1:0] length,
    output logic             out_valid,
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [STR_W-1:0] string_q, string_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             abort_c;

`ifdef STRING_ASSEMBLER_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Next-state: lane write decode, count, length capture and handoff.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        string_d    = string_q;
        length_d    = length_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            FILL: begin
                if (abort_c) begin
                    count_d  = '0;
                    string_d = '0;
                end else if (in_valid && in_ready_q) begin
                    if (in_byte == NUL) begin
                        length_d = count_q;
                        state_d  = DONE;
                    end else begin
                        for (int unsigned i = 0; i < STR_BYTES; i++) begin
                            if (count_q == LEN_W'(i)) begin
                                string_d[i*8 +: 8] = in_byte;
                            end
                        end
                        count_d = count_q + LEN_W'(1);
                        // A full string terminates itself without a NUL.
                        if (count_q == LEN_W'(STR_BYTES - 1)) begin
                            length_d = LEN_W'(STR_BYTES);
                            state_d  = DONE;
                        end
                    end
                end
            end
            DONE: begin
                // Lanes above length are already zero because the word is
                // cleared on every handoff and abort.
                if (out_ready) begin
                    string_d = '0;
                    count_d  = '0;
                    length_d = '0;
                    state_d  = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            count_q     <= '0;
            string_q    <= '0;
            length_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            string_q    <= string_d;
            length_q    <= length_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign string_data = string_q;
    assign length      = length_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_string_assembler.sv
// Scoreboard bench for string_assembler: the driver models accepted bytes as a
// character queue and pushes each completed string; a negedge monitor pops and
// compares on every handshake and checks hold stability and length_finder.
module tb_string_assembler;
    import string_pkg::*;

    logic        clk;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] string_data;
    logic [3:0]  length;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  lf_len;
`ifdef STRING_ASSEMBLER_ABORT_EN
    logic        abort;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    byte unsigned cur[$];
    logic [63:0]  exp_str[$];
    logic [3:0]   exp_len[$];
    bit           rand_mode  = 1'b0;
    bit           hold_ready = 1'b1;

    string_assembler dut (
        .clk        (clk),
        .reset      (reset),
`ifdef STRING_ASSEMBLER_ABORT_EN
        .abort      (abort),
`endif
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .string_data(string_data),
        .length     (length),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    length_finder u_lf (
        .str_in(string_data),
        .len_c (lf_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference: a completed string is the accepted characters packed from lane 0.
    task automatic finish_string();
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < cur.size(); i++) s[8*i +: 8] = cur[i];
        exp_str.push_back(s);
        exp_len.push_back(4'(cur.size()));
        cur.delete();
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("done_in_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic model_accept(input byte unsigned b);
        if (b == 8'h00) begin
            finish_string();
        end else begin
            cur.push_back(b);
            if (cur.size() == 8) finish_string();
        end
    endtask

    // Called at posedge+1; waits for in_ready, throwing ignored junk at DONE.
    task automatic send(input byte unsigned b, input int gap);
        int guard;
        guard = 0;
        repeat (gap) begin @(posedge clk); #1; end
        while (!in_ready && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = 8'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_byte  = b;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            model_accept(b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("rst_string", string_data, 64'h0);
        check("rst_length", 64'(length), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        cur.delete();
        exp_str.delete();
        exp_len.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Consumer: out_ready changes only just after rising edges.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : hold_ready;
        end
    end

    // Monitor: handshake pops, hold stability, length_finder agreement.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_str;
    logic [3:0]  prev_len;
    always @(negedge clk) begin
        if (reset) begin
            prev_hold <= 1'b0;
        end else if (out_valid) begin
            check("length_finder", 64'(lf_len), 64'(length));
            if (prev_hold) begin
                check("hold_string", string_data, prev_str);
                check("hold_length", 64'(length), 64'(prev_len));
            end
            if (out_ready) begin
                if (exp_str.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    check("out_string", string_data, exp_str.pop_front());
                    check("out_length", 64'(length), 64'(exp_len.pop_front()));
                end
                prev_hold <= 1'b0;
            end else begin
                prev_hold <= 1'b1;
                prev_str  <= string_data;
                prev_len  <= length;
            end
        end else begin
            prev_hold <= 1'b0;
        end
    end

    initial begin
        int guard;
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
`ifdef STRING_ASSEMBLER_ABORT_EN
        abort    = 1'b0;
`endif
        #12;
        check("init_string", string_data, 64'h0);
        check("init_length", 64'(length), 64'd0);
        check("init_out_valid", 64'(out_valid), 64'd0);
        check("init_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Full string without terminator.
        send(8'h99, 0); send(8'hAA, 0); send(8'hFF, 0); send(8'hEE, 0);
        send(8'hDD, 0); send(8'hCC, 0); send(8'hBB, 0); send(8'hAA, 0);

        // Held output with out_ready low.
        hold_ready = 1'b0;
        send(8'hAA, 0); send(8'hFF, 0); send(8'h00, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        hold_ready = 1'b1;

        // Empty string, then handoff bubble.
        send(8'h00, 0);
        @(posedge clk); #2;
        check("handoff_fill", 64'(in_ready), 64'd1);
        check("handoff_clear", string_data, 64'h0);
        send(8'hAA, 0); send(8'h00, 0);

        // Reset mid-string.
        send(8'hAA, 0); send(8'hFF, 0); send(8'h44, 0);
        do_reset();
        send(8'h11, 0); send(8'h00, 0);

        // Reset while a completed string is pending.
        hold_ready = 1'b0;
        send(8'h55, 0); send(8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        hold_ready = 1'b1;

        // Gapped input.
        send(8'hAA, 0); send(8'hFF, 1); send(8'h00, 2);

`ifdef STRING_ASSEMBLER_ABORT_EN
        send(8'hAA, 0); send(8'hFF, 0);
        abort = 1'b1; in_valid = 1'b1; in_byte = 8'h33;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        cur.delete();
        send(8'h44, 0); send(8'h00, 0);
`endif

        // Randomized strings with random consumer back-pressure.
        rand_mode = 1'b1;
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) send(8'($urandom_range(1, 255)), $urandom_range(0, 2));
            if (n < 8) send(8'h00, $urandom_range(0, 1));
        end

        // Drain.
        rand_mode  = 1'b0;
        hold_ready = 1'b1;
        guard = 0;
        while (exp_str.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", 64'(exp_str.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
